// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl shared types: sequencer states and write-source ids.
// Imported by the controller and its write arbiter.
package rf_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } rf_ctrl_state_e;

    typedef enum logic {
        WB = 1'b0,
        LD = 1'b1
    } wr_src_e;

endpackage

// File: rtl/rf_ctrl_wr_rr_arb.sv
// Two-way round-robin arbiter between ALU writeback and load return.
// gnt_o[0] = wb, gnt_o[1] = ld; history advances only on take_i.
module rf_wr_rr_arb
    import rf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       asyn_n_rst,
    input  logic       wb_valid_i,
    input  logic       ld_valid_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    wr_src_e last_wr_q;
    wr_src_e last_wr_d;
    logic    gnt_wb;

    // On a tie the source that did not win last time goes first.
    always_comb begin
        gnt_wb = wb_valid_i & (~ld_valid_i | (last_wr_q == LD));
        gnt_o  = {ld_valid_i & ~gnt_wb, gnt_wb};
        last_wr_d = last_wr_q;
        if (take_i) begin
            last_wr_d = gnt_wb ? WB : LD;
        end
    end

    // History starts at ld so that wb wins the first tie.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            last_wr_q <= LD;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: rtl/rf_ctrl.sv
// Register-file sequencer: clears all entries after reset, then grants
// one read or one write per cycle with round-robin writes and read aging.
module rf_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int RF_ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH       = 16,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        asyn_n_rst,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [RF_ADDRESS_WIDTH-1:0] rd_rs1,
    input  logic [RF_ADDRESS_WIDTH-1:0] rd_rs2,
    output logic                        rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_qs1,
    output logic [DATA_WIDTH-1:0]       rsp_qs2,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [RF_ADDRESS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [RF_ADDRESS_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0]       ld_data,
    output logic                        rf_we,
    output logic [RF_ADDRESS_WIDTH-1:0] rf_rs1,
    output logic [RF_ADDRESS_WIDTH-1:0] rf_rs2,
    output logic [RF_ADDRESS_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]       rf_data_in,
    input  logic [DATA_WIDTH-1:0]       rf_qs1,
    input  logic [DATA_WIDTH-1:0]       rf_qs2,
    output logic                        init_done
);

    localparam int AW   = RF_ADDRESS_WIDTH;
    localparam int NREG = 2 ** AW;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    localparam logic [AW-1:0] CLR_LAST = AW'(NREG - 1);
    localparam logic [SW-1:0] SLIM     = SW'(STARVE_LIMIT);

    rf_ctrl_state_e state_q;
    rf_ctrl_state_e state_d;

    logic [AW-1:0]         clr_cnt_q;
    logic [AW-1:0]         clr_cnt_d;
    logic [SW-1:0]         starve_q;
    logic [SW-1:0]         starve_d;
    logic                  rsp_valid_q;
    logic                  rs1_zero_q;
    logic                  rs2_zero_q;
    logic [AW-1:0]         rs1_q;
    logic [AW-1:0]         rs2_q;
    logic [AW-1:0]         rd_q;
    logic [DATA_WIDTH-1:0] din_q;

    logic       run;
    logic       any_wr;
    logic       rd_gnt;
    logic       take;
    logic [1:0] gnt;

    assign run    = (state_q == RUN);
    assign any_wr = wb_valid | ld_valid;
    assign rd_gnt = run & rd_req_valid
                  & ((starve_q == SLIM) | ~any_wr);

    rf_wr_rr_arb u_arb (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .wb_valid_i (wb_valid),
        .ld_valid_i (ld_valid),
        .take_i     (take),
        .gnt_o      (gnt)
    );

    // State register.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one idle cycle, one pass over all entries, then run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET:   state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == CLR_LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RESET;
        endcase
    end

    // Outputs: clear sweep, then a single read or write grant per cycle.
    always_comb begin
        rd_req_ready = 1'b0;
        wb_ready     = 1'b0;
        ld_ready     = 1'b0;
        take         = 1'b0;
        rf_we        = 1'b0;
        rf_rs1       = rs1_q;
        rf_rs2       = rs2_q;
        rf_rd        = rd_q;
        rf_data_in   = din_q;
        unique case (state_q)
            RESET: begin
                rf_rs1     = '0;
                rf_rs2     = '0;
                rf_rd      = '0;
                rf_data_in = '0;
            end
            CLEAR: begin
                rf_we      = 1'b1;
                rf_rd      = clr_cnt_q;
                rf_data_in = '0;
            end
            RUN: begin
                if (rd_gnt) begin
                    rd_req_ready = 1'b1;
                    rf_rs1       = rd_rs1;
                    rf_rs2       = rd_rs2;
                end else if (any_wr) begin
                    take = 1'b1;
                    if (gnt[0]) begin
                        wb_ready   = 1'b1;
                        rf_rd      = wb_rd;
                        rf_data_in = wb_data;
                        rf_we      = (wb_rd != '0);
                    end else begin
                        ld_ready   = 1'b1;
                        rf_rd      = ld_rd;
                        rf_data_in = ld_data;
                        rf_we      = (ld_rd != '0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Sweep counter and read-aging counter.
    always_comb begin
        clr_cnt_d = (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
        starve_d  = '0;
        if (run && rd_req_valid && !rd_gnt) begin
            starve_d = (starve_q == SLIM) ? starve_q : starve_q + 1'b1;
        end
    end

    // Counters, held rf outputs and the read response register.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            clr_cnt_q   <= '0;
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rs1_zero_q  <= 1'b0;
            rs2_zero_q  <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            din_q       <= '0;
        end else begin
            clr_cnt_q   <= clr_cnt_d;
            starve_q    <= starve_d;
            rsp_valid_q <= rd_gnt;
            if (rd_gnt) begin
                rs1_zero_q <= (rd_rs1 == '0);
                rs2_zero_q <= (rd_rs2 == '0);
            end
            rs1_q <= rf_rs1;
            rs2_q <= rf_rs2;
            rd_q  <= rf_rd;
            din_q <= rf_data_in;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_qs1   = rs1_zero_q ? '0 : rf_qs1;
    assign rsp_qs2   = rs2_zero_q ? '0 : rf_qs2;
    assign init_done = run;

endmodule

// File: tb/tb_rf_ctrl.sv
// Bench for rf_ctrl: a behavioural rf with registered reads, a vector
// table for steady-state arbitration, and sequences for init and reset.
module tb_rf_ctrl;

    logic        clk = 1'b0;
    logic        asyn_n_rst;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rd_rs1;
    logic [4:0]  rd_rs2;
    logic        rsp_valid;
    logic [15:0] rsp_qs1;
    logic [15:0] rsp_qs2;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [15:0] wb_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [15:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [4:0]  rf_rd;
    logic [15:0] rf_data_in;
    logic [15:0] rf_qs1;
    logic [15:0] rf_qs2;
    logic        init_done;
    logic        poison;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rf_ctrl #(
        .RF_ADDRESS_WIDTH (5),
        .DATA_WIDTH       (16),
        .STARVE_LIMIT     (4)
    ) dut (
        .clk          (clk),
        .asyn_n_rst   (asyn_n_rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rs1       (rd_rs1),
        .rd_rs2       (rd_rs2),
        .rsp_valid    (rsp_valid),
        .rsp_qs1      (rsp_qs1),
        .rsp_qs2      (rsp_qs2),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .rf_we        (rf_we),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rd        (rf_rd),
        .rf_data_in   (rf_data_in),
        .rf_qs1       (rf_qs1),
        .rf_qs2       (rf_qs2),
        .init_done    (init_done)
    );

    // rf model: entries start as junk, r0 is not stored and reads junk,
    // so both the clear sweep and rsp zeroing are observable.
    logic [15:0] mem [32];
    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'hDEAD;
        end else if (rf_we) begin
            mem[rf_rd] <= rf_data_in;
        end else begin
            rf_qs1 <= (rf_rs1 == 5'd0) ? 16'hBAD0 : mem[rf_rs1];
            rf_qs2 <= (rf_rs2 == 5'd0) ? 16'hBAD0 : mem[rf_rs2];
        end
    end

    typedef struct {
        logic        rv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wv;
        logic [4:0]  wrd;
        logic [15:0] wd;
        logic        lv;
        logic [4:0]  lrd;
        logic [15:0] ldd;
        logic        e_rr;
        logic        e_wr;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [15:0] e_din;
        logic        e_rsp;
        logic [15:0] e_q1;
        logic [15:0] e_q2;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(
        input logic rv, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic wv, input logic [4:0] wrd, input logic [15:0] wd,
        input logic lv, input logic [4:0] lrd, input logic [15:0] ldd,
        input logic e_rr, input logic e_wr, input logic e_lr,
        input logic e_we, input logic [4:0] e_rd,
        input logic [15:0] e_din, input logic e_rsp,
        input logic [15:0] e_q1, input logic [15:0] e_q2);
        vec_t v;
        v.rv = rv; v.rs1 = rs1; v.rs2 = rs2;
        v.wv = wv; v.wrd = wrd; v.wd = wd;
        v.lv = lv; v.lrd = lrd; v.ldd = ldd;
        v.e_rr = e_rr; v.e_wr = e_wr; v.e_lr = e_lr;
        v.e_we = e_we; v.e_rd = e_rd; v.e_din = e_din;
        v.e_rsp = e_rsp; v.e_q1 = e_q1; v.e_q2 = e_q2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req_valid = 1'b0;
        rd_rs1 = '0; rd_rs2 = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    endtask

    // Release reset and follow the sweep until init_done.
    task automatic release_and_wait(input string tag);
        int cyc;
        int nclr;
        cyc  = 0;
        nclr = 0;
        asyn_n_rst = 1'b1;
        while (!init_done && cyc < 100) begin
            step();
            cyc++;
            if (!init_done && rf_we && rf_rd == 5'(cyc - 1)
                && rf_data_in == 16'h0 && !wb_ready)
                nclr++;
        end
        chk({tag, "_init_cycles"}, cyc, 33);
        chk({tag, "_clear_writes"}, nclr, 32);
    endtask

    initial begin
        idle_inputs();
        asyn_n_rst = 1'b0;
        poison = 1'b1;
        repeat (3) step();
        poison = 1'b0;

        chk("rst_init_done", init_done, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_din", rf_data_in, 0);

        release_and_wait("init");

        // Read r5 in the first RUN cycle: swept to zero.
        rd_req_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd5;
        @(negedge clk);
        chk("r5_rd_ready", rd_req_ready, 1);
        chk("r5_we", rf_we, 0);
        chk("r5_rs1", rf_rs1, 5);
        step();
        rd_req_valid = 1'b0;
        @(negedge clk);
        chk("r5_rsp_valid", rsp_valid, 1);
        chk("r5_qs1", rsp_qs1, 16'h0);
        chk("r5_qs2", rsp_qs2, 16'h0);
        step();

        // rv rs1 rs2 | wv wrd wd | lv lrd ld |
        // rr wr lr we rd din | rsp q1 q2
        tv[0]  = mk(0,0,0, 1,3,16'h1234, 0,0,0,
                    0,1,0,1,3,16'h1234, 0,0,0);
        tv[1]  = mk(1,3,3, 0,0,0, 0,0,0,
                    1,0,0,0,3,16'h1234, 0,0,0);
        tv[2]  = mk(0,0,0, 0,0,0, 0,0,0,
                    0,0,0,0,3,16'h1234, 1,16'h1234,16'h1234);
        tv[3]  = mk(0,0,0, 1,1,16'hAAAA, 1,2,16'h5555,
                    0,0,1,1,2,16'h5555, 0,0,0);
        tv[4]  = mk(0,0,0, 1,1,16'hAAAA, 1,2,16'h5555,
                    0,1,0,1,1,16'hAAAA, 0,0,0);
        tv[5]  = mk(0,0,0, 1,1,16'hAAAA, 1,2,16'h5555,
                    0,0,1,1,2,16'h5555, 0,0,0);
        tv[6]  = mk(0,0,0, 1,1,16'hAAAA, 1,2,16'h5555,
                    0,1,0,1,1,16'hAAAA, 0,0,0);
        tv[7]  = mk(0,0,0, 0,0,0, 1,0,16'hFFFF,
                    0,0,1,0,0,16'hFFFF, 0,0,0);
        tv[8]  = mk(1,0,1, 0,0,0, 0,0,0,
                    1,0,0,0,0,16'hFFFF, 0,0,0);
        tv[9]  = mk(0,0,0, 0,0,0, 0,0,0,
                    0,0,0,0,0,16'hFFFF, 1,16'h0,16'hAAAA);
        for (int i = 10; i < 14; i++)
            tv[i] = mk(1,4,2, 1,4,16'h4444, 0,0,0,
                       0,1,0,1,4,16'h4444, 0,0,0);
        tv[14] = mk(1,4,2, 1,4,16'h4444, 0,0,0,
                    1,0,0,0,4,16'h4444, 0,0,0);
        tv[15] = mk(1,4,2, 1,4,16'h4444, 0,0,0,
                    0,1,0,1,4,16'h4444, 1,16'h4444,16'h5555);
        tv[16] = mk(0,0,0, 0,0,0, 0,0,0,
                    0,0,0,0,4,16'h4444, 0,0,0);

        for (int i = 0; i < 17; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            rd_req_valid = tv[i].rv;
            rd_rs1 = tv[i].rs1; rd_rs2 = tv[i].rs2;
            wb_valid = tv[i].wv;
            wb_rd = tv[i].wrd; wb_data = tv[i].wd;
            ld_valid = tv[i].lv;
            ld_rd = tv[i].lrd; ld_data = tv[i].ldd;
            @(negedge clk);
            chk({t, "_rd_ready"}, rd_req_ready, tv[i].e_rr);
            chk({t, "_wb_ready"}, wb_ready, tv[i].e_wr);
            chk({t, "_ld_ready"}, ld_ready, tv[i].e_lr);
            chk({t, "_we"}, rf_we, tv[i].e_we);
            chk({t, "_rf_rd"}, rf_rd, tv[i].e_rd);
            chk({t, "_rf_din"}, rf_data_in, tv[i].e_din);
            chk({t, "_rsp_valid"}, rsp_valid, tv[i].e_rsp);
            if (tv[i].e_rsp) begin
                chk({t, "_qs1"}, rsp_qs1, tv[i].e_q1);
                chk({t, "_qs2"}, rsp_qs2, tv[i].e_q2);
            end
            step();
        end
        idle_inputs();

        // Reset lands right after a read grant: no response escapes.
        rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd3;
        @(negedge clk);
        chk("mid_rd_ready", rd_req_ready, 1);
        #1 asyn_n_rst = 1'b0;
        #1;
        chk("mid_rst_rsp_now", rsp_valid, 0);
        step();
        idle_inputs();
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_we", rf_we, 0);
        step();
        release_and_wait("rerun");

        // History is back to ld, so wb wins the first tie.
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 16'h6666;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 16'h7777;
        @(negedge clk);
        chk("tie1_wb_ready", wb_ready, 1);
        chk("tie1_ld_ready", ld_ready, 0);
        chk("tie1_rf_rd", rf_rd, 6);
        step();
        @(negedge clk);
        chk("tie2_wb_ready", wb_ready, 0);
        chk("tie2_ld_ready", ld_ready, 1);
        chk("tie2_rf_rd", rf_rd, 7);
        step();
        idle_inputs();
        rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd6;
        @(negedge clk);
        chk("post_rd_ready", rd_req_ready, 1);
        step();
        rd_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 1);
        chk("post_r3_cleared", rsp_qs1, 16'h0);
        chk("post_r6_raw", rsp_qs2, 16'h6666);
        step();
        @(negedge clk);
        chk("post_rsp_pulse", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
